// File: rtl/window_3x3_generator.sv
// Streaming 3x3 neighbourhood builder for raster-order RGB444 pixels.
// Two line buffers supply rows r-2 and r-1; only interior windows are emitted.
module window_3x3_generator #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int PIX_W      = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic                 in_sof,
    input  logic [PIX_W-1:0]     in_data,
    output logic                 win_valid,
    output logic [9*PIX_W-1:0]   win_data,
    output logic                 frame_done
);

    localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    logic [CW-1:0]    col_q;
    logic [CW-1:0]    col_cur;
    logic [RW-1:0]    row_q;
    logic [RW-1:0]    row_cur;
    logic             last_col;
    logic             last_row;
    logic             win_hit;

    logic [PIX_W-1:0] lb0 [IMG_WIDTH];
    logic [PIX_W-1:0] lb1 [IMG_WIDTH];
    logic [PIX_W-1:0] top_rd;
    logic [PIX_W-1:0] mid_rd;

    // Shift window columns: *1 holds column c-1, *2 holds column c-2.
    logic [PIX_W-1:0] top1, top2;
    logic [PIX_W-1:0] mid1, mid2;
    logic [PIX_W-1:0] bot1, bot2;

    // A start-of-frame pixel is placed at (0,0) whatever the counters say.
    always_comb begin
        col_cur = col_q;
        row_cur = row_q;
        if (in_sof) begin
            col_cur = '0;
            row_cur = '0;
        end
    end

    assign last_col = (col_cur == CW'(IMG_WIDTH - 1));
    assign last_row = (row_cur == RW'(IMG_HEIGHT - 1));
    assign win_hit  = in_valid && (row_cur >= RW'(2)) && (col_cur >= CW'(2));

    assign top_rd = lb0[col_cur];
    assign mid_rd = lb1[col_cur];

    // Line buffers carry no reset: rows 0 and 1 of every frame are written
    // before any window reads them.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            lb0[col_cur] <= mid_rd;
            lb1[col_cur] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_q      <= '0;
            row_q      <= '0;
            top1       <= '0;
            top2       <= '0;
            mid1       <= '0;
            mid2       <= '0;
            bot1       <= '0;
            bot2       <= '0;
            win_valid  <= 1'b0;
            win_data   <= '0;
            frame_done <= 1'b0;
        end else begin
            win_valid  <= win_hit;
            frame_done <= win_hit && last_row && last_col;
            if (in_valid) begin
                if (last_col) begin
                    col_q <= '0;
                    row_q <= last_row ? '0 : row_cur + RW'(1);
                end else begin
                    col_q <= col_cur + CW'(1);
                    row_q <= row_cur;
                end
                top2 <= top1;
                top1 <= top_rd;
                mid2 <= mid1;
                mid1 <= mid_rd;
                bot2 <= bot1;
                bot1 <= in_data;
            end
            // Fields: C, left, right, up, down, upleft, upright, downleft, downright.
            if (win_hit) begin
                win_data <= {mid1, mid2, mid_rd, top1, bot1, top2, top_rd, bot2, in_data};
            end
        end
    end

endmodule

// File: doc/window_3x3_generator.md
Name: window_3x3_generator

Overview:
- Streaming upstream stage of the image filter chain. Accepts raster-order RGB444 pixels and builds each 3x3 neighbourhood using two internal line buffers.
- Emits the neighbourhood as one 108-bit packed word on the interface the downstream filter consumes (e.g. grayscale_filter_module.color_data).
- Only interior windows are produced: every center pixel has all 8 neighbours inside the frame.

Parameters:
- IMG_WIDTH, 640, pixels per line; legal range 3..4096.
- IMG_HEIGHT, 480, lines per frame; legal range 3..4096.
- PIX_W, 12, bits per pixel (RGB444). Fixed; any other value is unsupported.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high.
- in_valid  input  1  in_data is a valid pixel this cycle.
- in_sof  input  1  qualifies in_valid: this pixel is (row 0, col 0) of a new frame.
- in_data  input  12  pixel {R[11:8],G[7:4],B[3:0]}.
- win_valid  output  1  win_data holds a new window this cycle (1-cycle pulse per window).
- win_data  output  108  packed 3x3 window, layout below.
- frame_done  output  1  1-cycle pulse with the last window of a frame.

Behaviour:
- Reset is asynchronous, active-high; clock is clk. On reset:
  - win_valid=0, win_data=0, frame_done=0.
  - Column and row counters=0; window registers=0.
  - Line buffer contents are don't-care, never read before being written in a frame.
- No backpressure. One pixel may be accepted per cycle; in_valid may have arbitrary gaps. State advances only on in_valid=1.
- Counters col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1) give the position of the accepted pixel.
  - col wraps to 0 and row increments after IMG_WIDTH-1.
  - row wraps to 0 after the last pixel of the frame.
- in_sof=1 with in_valid=1 forces the accepted pixel to (0,0) regardless of counter state. The frame restarts; no partial-frame window or frame_done is produced afterwards for the aborted frame.
- Line buffers: LB1 holds row r-1, LB0 holds row r-2, each depth IMG_WIDTH, indexed by col.
  - Per accepted pixel: read LB0[col] and LB1[col], then write LB0[col]<=old LB1[col] and LB1[col]<=in_data (read-before-write).
  - Read data and in_data feed a 3-column shift window (top=r-2, mid=r-1, bottom=r).
- Window emission: accepting the pixel at (r,c) with r>=2 and c>=2 completes the window centred at (r-1,c-1).
  - Exactly one cycle later: win_valid=1 and win_data is loaded; latency is 1 clk from accepting pixel (r,c).
  - win_data holds its value until the next window.
- Windows per frame: (IMG_WIDTH-2)*(IMG_HEIGHT-2). Column wrap must not mix pixels from different lines into a window.
- win_data packing (center = C = pixel (r-1,c-1)):
  - [107:96] C
  - [95:84] left (r-1,c-2)
  - [83:72] right (r-1,c)
  - [71:60] up (r-2,c-1)
  - [59:48] down (r,c-1)
  - [47:36] upleft (r-2,c-2)
  - [35:24] upright (r-2,c)
  - [23:12] downleft (r,c-2)
  - [11:0] downright (r,c)
- frame_done=1 in the same cycle as the win_valid for pixel (IMG_HEIGHT-1, IMG_WIDTH-1); 0 otherwise.
- Reset asserted mid-frame: outputs clear immediately. The first window after deassertion needs a full new frame starting at (0,0); in_sof is not required after reset.
- Pixel values pass through unmodified; no arithmetic on data.

Test Plan:
- IMG_WIDTH=4, IMG_HEIGHT=4, continuous in_valid, in_sof on first pixel, in_data=4*r+c -> 4 windows. First window is 1 clk after pixel (2,2), centre 5: win_data fields C=5, left=4, right=6, up=1, down=9, upleft=0, upright=2, downleft=8, downright=10. Last window has centre 10 with frame_done=1.
- Same frame with in_valid toggling 1/0 every cycle -> identical window contents and count; each win_valid exactly 1 clk after its completing pixel.
- Two back-to-back frames, second frame data = 4*r+c+100 -> second frame windows carry no first-frame data; first window centre=105, upleft=100.
- Mid-frame in_sof after 7 pixels, then a full frame -> only the new frame's 4 windows appear, with no frame_done for the aborted frame.
- reset pulse during row 2 -> win_valid/win_data/frame_done=0 immediately. Next full frame of 16 pixels without in_sof -> correct 4 windows.
- IMG_WIDTH=640, IMG_HEIGHT=480 random frame -> 638*478 windows match a reference model, and exactly one frame_done.
